// File: rtl/ec_pkg.sv
// ec_pkg: opcode and FSM state encodings plus the accumulator ALU shared by the ec_core_p core.
package ec_pkg;
    localparam int ALU_W = 64;

    typedef enum logic [3:0] {
        OP_LOAD, OP_STORE, OP_ADD, OP_SUB, OP_IN, OP_JZ, OP_JPOS, OP_HALT,
        OP_AND, OP_OR, OP_XOR, OP_JMP, OP_OUT, OP_INC, OP_DEC, OP_SHR
    } opcode_e;

    typedef enum logic [2:0] {S_HALT, S_FETCH, S_EXEC, S_WAIT_IN, S_WAIT_OUT} state_e;

    // A arrives sign-extended and M zero-extended to ALU_W; the caller truncates the result.
    function automatic logic [ALU_W-1:0] exec_alu(input opcode_e op, input logic [ALU_W-1:0] a,
                                                   input logic [ALU_W-1:0] m);
        case (op)
            OP_LOAD: return m;
            OP_ADD:  return a + m;
            OP_SUB:  return a - m;
            OP_AND:  return a & m;
            OP_OR:   return a | m;
            OP_XOR:  return a ^ m;
            OP_INC:  return a + ALU_W'(1);
            OP_DEC:  return a - ALU_W'(1);
            OP_SHR:  return {a[ALU_W-1], a[ALU_W-1:1]};
            default: return a;
        endcase
    endfunction
endpackage

// File: rtl/ec_mem.sv
// ec_mem: unified program/data memory, asynchronous read and one synchronous write port.
module ec_mem #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);
    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/ec_core_p.sv
// ec_core_p: parametrised accumulator core with FSM, PC/IR/A, valid/ready I/O and a host load port.
module ec_core_p
    import ec_pkg::*;
#(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_wdata,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              Halt,
    output logic [DATA_W-1:0] Data_output
);
    state_e              r_state, w_next;
    logic [ADDR_W-1:0]   r_pc;
    logic [ADDR_W+3:0]   r_ir;
    logic [DATA_W-1:0]   r_a, r_out_data, w_rdata, w_wdata, w_alu;
    logic [ADDR_W-1:0]   w_addr, w_waddr, w_raddr;
    opcode_e             w_op;
    logic                w_we, w_take;

    assign w_op   = opcode_e'(r_ir[ADDR_W+3:ADDR_W]);
    assign w_addr = r_ir[ADDR_W-1:0];

    // The host owns the write port only while halted; STORE only during EXEC.
    assign w_we    = (r_state == S_HALT && prog_we) || (r_state == S_EXEC && w_op == OP_STORE);
    assign w_waddr = r_state == S_HALT ? prog_addr : w_addr;
    assign w_wdata = r_state == S_HALT ? prog_wdata : r_a;
    assign w_raddr = r_state == S_FETCH ? r_pc : w_addr;

    ec_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem (
        .clk     (Clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    assign w_alu  = DATA_W'(exec_alu(w_op, {{(ALU_W-DATA_W){r_a[DATA_W-1]}}, r_a}, ALU_W'(w_rdata)));
    assign w_take = w_op == OP_JMP || (w_op == OP_JZ && r_a == '0) ||
                    (w_op == OP_JPOS && !r_a[DATA_W-1] && r_a != '0);

    always_comb begin
        w_next    = r_state;
        Halt      = r_state == S_HALT;
        in_ready  = r_state == S_WAIT_IN;
        out_valid = r_state == S_WAIT_OUT;
        case (r_state)
            S_HALT:     w_next = start ? S_FETCH : S_HALT;
            S_FETCH:    w_next = S_EXEC;
            S_EXEC:     w_next = w_op == OP_IN   ? S_WAIT_IN  :
                                 w_op == OP_OUT  ? S_WAIT_OUT :
                                 w_op == OP_HALT ? S_HALT     : S_FETCH;
            S_WAIT_IN:  w_next = in_valid  ? S_FETCH : S_WAIT_IN;
            S_WAIT_OUT: w_next = out_ready ? S_FETCH : S_WAIT_OUT;
            default:    w_next = S_HALT;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state    <= S_HALT;
            r_pc       <= '0;
            r_ir       <= '0;
            r_a        <= '0;
            r_out_data <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_HALT: begin
                    if (start) begin
                        r_pc <= '0;
                        r_a  <= '0;
                    end
                end
                S_FETCH: begin
                    r_ir <= w_rdata[ADDR_W+3:0];
                    r_pc <= r_pc + ADDR_W'(1);
                end
                S_EXEC: begin
                    r_a <= w_alu;
                    if (w_take) r_pc <= w_addr;
                    if (w_op == OP_OUT) r_out_data <= r_a;
                end
                S_WAIT_IN: begin
                    if (in_valid) r_a <= in_data;
                end
                default: ;
            endcase
        end
    end

    assign out_data    = r_out_data;
    assign Data_output = r_a;
endmodule

// File: tb/tb_ec_core_p.sv
// tb_ec_core_p: directed and random programs checked against an instruction-level ISA model.
module tb_ec_core_p;
    localparam int DW  = 12;
    localparam int AW  = 8;
    localparam int MSK = (1 << DW) - 1;

    logic          Clk = 0, Reset = 0, start = 0, prog_we = 0;
    logic [AW-1:0] prog_addr = '0;
    logic [DW-1:0] prog_wdata = '0, in_data = '0, out_data, Data_output;
    logic          in_valid = 0, in_ready, out_valid, out_ready = 0, Halt;

    int n_vec = 0, n_err = 0;
    int mem [256];

    ec_core_p #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .Clk(Clk), .Reset(Reset), .start(start), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_wdata(prog_wdata), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .Halt(Halt),
        .Data_output(Data_output)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int enc(input int op, input int ad);
        return (op << 8) | ad;
    endfunction

    task automatic load(input int ad, input int d);
        @(negedge Clk);
        prog_we    = 1;
        prog_addr  = ad[AW-1:0];
        prog_wdata = d[DW-1:0];
        mem[ad]    = d & MSK;
        @(negedge Clk);
        prog_we = 0;
    endtask

    // Instruction-level interpreter of the ISA; updates the memory mirror on STORE.
    task automatic model(input int ins[$], output int outs[$], output int a);
        int pc = 0, k = 0, ir, op, ad;
        a = 0;
        outs = {};
        for (int s = 0; s < 4000; s++) begin
            ir = mem[pc];
            pc = (pc + 1) % 256;
            op = (ir >> 8) & 15;
            ad = ir & 255;
            case (op)
                0:  a = mem[ad];
                1:  mem[ad] = a;
                2:  a = (a + mem[ad]) & MSK;
                3:  a = (a - mem[ad]) & MSK;
                4:  begin a = k < ins.size() ? ins[k] : 0; k++; end
                5:  if (a == 0) pc = ad;
                6:  if (a != 0 && a < 2048) pc = ad;
                7:  return;
                8:  a = a & mem[ad];
                9:  a = a | mem[ad];
                10: a = a ^ mem[ad];
                11: pc = ad;
                12: outs.push_back(a);
                13: a = (a + 1) & MSK;
                14: a = (a - 1) & MSK;
                default: a = (a >> 1) | (a & 2048);
            endcase
        end
    endtask

    // Runs the loaded program with random handshake pressure and compares against the model.
    task automatic run_prog(input string tag, input int pct);
        int ins[$], outs[$], a, k = 0, j = 0, cyc = 0, e;
        for (int i = 0; i < 32; i++) ins.push_back($urandom & MSK);
        model(ins, outs, a);
        @(negedge Clk);
        start = 1;
        @(negedge Clk);
        start = 0;
        while (!Halt && cyc < 20000) begin
            in_valid  = $urandom_range(0, 99) < pct;
            in_data   = (in_ready && k < ins.size()) ? ins[k][DW-1:0] : DW'($urandom);
            out_ready = $urandom_range(0, 99) < pct;
            if (in_valid && in_ready) k++;
            if (out_valid && out_ready) begin
                e = j < outs.size() ? outs[j] : -1;
                chk({tag, "_out"}, 32'(out_data), e);
                j++;
            end
            @(negedge Clk);
            cyc++;
        end
        in_valid  = 0;
        out_ready = 0;
        chk({tag, "_halt"}, 32'(Halt), 1);
        chk({tag, "_nout"}, j, outs.size());
        chk({tag, "_a"}, 32'(Data_output), a);
    endtask

    initial begin
        repeat (2) @(negedge Clk);
        chk("rst_halt", 32'(Halt), 1);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_a", 32'(Data_output), 0);
        Reset = 1;

        // IN with a late producer, then OUT
        load(0, enc(4, 0)); load(1, enc(12, 0)); load(2, enc(7, 0));
        out_ready = 1;
        @(negedge Clk); start = 1;
        @(negedge Clk); start = 0;
        for (int c = 0; c < 20 && !in_ready; c++) @(negedge Clk);
        for (int c = 0; c < 5; c++) begin
            chk("t1_in_ready_wait", 32'(in_ready), 1);
            in_valid = 1;
            in_valid = 0;
            @(negedge Clk);
        end
        in_valid = 1; in_data = 12'h00A;
        @(negedge Clk);
        in_valid = 0;
        chk("t1_a_after_in", 32'(Data_output), 12'h00A);
        chk("t1_in_ready_drop", 32'(in_ready), 0);
        for (int c = 0; c < 20 && !out_valid; c++) @(negedge Clk);
        chk("t1_out_valid", 32'(out_valid), 1);
        chk("t1_out_data", 32'(out_data), 12'h00A);
        for (int c = 0; c < 20 && !Halt; c++) @(negedge Clk);
        chk("t1_halt", 32'(Halt), 1);
        out_ready = 0;

        // countdown loop
        load(8'h20, 3);
        load(0, enc(0, 8'h20)); load(1, enc(14, 0)); load(2, enc(12, 0));
        load(3, enc(5, 5)); load(4, enc(11, 1)); load(5, enc(7, 0));
        run_prog("t2_countdown", 100);
        run_prog("t2_countdown_slow", 40);

        // OUT held off by the sink
        load(8'h21, 12'h5A5);
        load(0, enc(0, 8'h21)); load(1, enc(12, 0)); load(2, enc(13, 0));
        load(3, enc(12, 0)); load(4, enc(7, 0));
        @(negedge Clk); start = 1;
        @(negedge Clk); start = 0;
        for (int c = 0; c < 20 && !out_valid; c++) @(negedge Clk);
        for (int c = 0; c < 10; c++) begin
            chk("t3_hold_valid", 32'(out_valid), 1);
            chk("t3_hold_data", 32'(out_data), 12'h5A5);
            @(negedge Clk);
        end
        out_ready = 1;
        @(negedge Clk);
        out_ready = 0;
        chk("t3_valid_drop", 32'(out_valid), 0);
        chk("t3_data_kept", 32'(out_data), 12'h5A5);
        chk("t3_next_fetch", 32'(Halt), 0);
        out_ready = 1;
        for (int c = 0; c < 30 && !Halt; c++) @(negedge Clk);
        chk("t3_halt", 32'(Halt), 1);
        chk("t3_last_out", 32'(out_data), 12'h5A6);
        out_ready = 0;

        // arithmetic and branch conditions
        load(8'h22, 12'h7FF); load(8'h23, 0); load(8'h24, 12'hFFF);
        load(0, enc(0, 8'h22)); load(1, enc(13, 0)); load(2, enc(12, 0));
        load(3, enc(6, 8'h10)); load(4, enc(15, 0)); load(5, enc(12, 0));
        load(6, enc(0, 8'h23)); load(7, enc(6, 8'h10)); load(8, enc(5, 8'h0A));
        load(9, enc(12, 0)); load(8'h0A, enc(0, 8'h24)); load(8'h0B, enc(13, 0));
        load(8'h0C, enc(12, 0)); load(8'h0D, enc(7, 0));
        load(8'h10, enc(12, 0)); load(8'h11, enc(7, 0));
        run_prog("t4_arith", 70);

        // host writes and start while running are ignored
        load(8'h40, 12'h123);
        load(0, enc(4, 0)); load(1, enc(0, 8'h40)); load(2, enc(12, 0)); load(3, enc(7, 0));
        out_ready = 1;
        @(negedge Clk); start = 1;
        @(negedge Clk); start = 0;
        for (int c = 0; c < 20 && !in_ready; c++) @(negedge Clk);
        prog_we = 1; prog_addr = 8'h40; prog_wdata = 12'h555; start = 1;
        @(negedge Clk);
        prog_addr = 8'h02; prog_wdata = 12'h700;
        @(negedge Clk);
        prog_we = 0; start = 0;
        chk("t5_running", 32'(Halt), 0);
        chk("t5_still_waiting", 32'(in_ready), 1);
        in_valid = 1; in_data = 12'h077;
        @(negedge Clk);
        in_valid = 0;
        for (int c = 0; c < 20 && !out_valid; c++) @(negedge Clk);
        chk("t5_out_data", 32'(out_data), 12'h123);
        for (int c = 0; c < 20 && !Halt; c++) @(negedge Clk);
        chk("t5_halt", 32'(Halt), 1);
        chk("t5_a", 32'(Data_output), 12'h123);
        out_ready = 0;
        run_prog("t5_readback", 80);

        // reset while waiting on the sink
        load(8'h41, 12'h3C3); load(8'h42, 12'h0FF);
        load(0, enc(0, 8'h41)); load(1, enc(12, 0)); load(2, enc(10, 8'h42));
        load(3, enc(12, 0)); load(4, enc(7, 0));
        @(negedge Clk); start = 1;
        @(negedge Clk); start = 0;
        for (int c = 0; c < 20 && !out_valid; c++) @(negedge Clk);
        chk("t6_out_before_rst", 32'(out_data), 12'h3C3);
        #2 Reset = 0;
        #1;
        chk("t6_rst_out_valid", 32'(out_valid), 0);
        chk("t6_rst_halt", 32'(Halt), 1);
        chk("t6_rst_a", 32'(Data_output), 0);
        @(negedge Clk);
        Reset = 1;
        run_prog("t6_rerun", 60);

        // random forward-only programs over a small data area
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 16; i++) load(8'h80 + i, $urandom & MSK);
            for (int i = 0; i < 20; i++) begin
                int op, ad;
                op = $urandom_range(0, 15);
                if (op == 7) op = 13;
                ad = (op == 5 || op == 6 || op == 11) ? $urandom_range(i + 1, 20) : $urandom_range(8'h80, 8'h8F);
                load(i, enc(op, ad));
            end
            load(20, enc(7, 0));
            run_prog($sformatf("rnd%0d", r), $urandom_range(30, 100));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
